// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_pkg
// Description : Shared types and lane helpers for the MIPS bus load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2
    } lsu_state_t;

    // The unused encoding 3 behaves as a full word.
    function automatic size_t norm_size(input logic [1:0] raw);
        return (raw == 2'd3) ? SZ_WORD : size_t'(raw);
    endfunction

    function automatic logic [3:0] lane_be(input size_t sz, input logic [1:0] o);
        case (sz)
            SZ_BYTE: return 4'b0001 << o;
            SZ_HALF: return o[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input size_t sz, input logic [31:0] data);
        case (sz)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input size_t sz, input logic sgn,
                                                 input logic [1:0] o, input logic [31:0] rdata);
        logic [31:0] sh;
        sh = '0;
        case (sz)
            SZ_BYTE: begin
                sh = rdata >> {o, 3'b000};
                return {{24{sgn & sh[7]}}, sh[7:0]};
            end
            SZ_HALF: begin
                sh = rdata >> {o[1], 4'b0000};
                return {{16{sgn & sh[15]}}, sh[15:0]};
            end
            default: return rdata;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] o);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return o[0];
            default: return (o != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_bus_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_lsu_if
// Description : Core request/response channel plus Avalon-MM master signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_bus_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic              waitrequest;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;

    // LSU side: bus master toward Avalon, server toward the core.
    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  waitrequest, readdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output address, read, write, writedata, byteenable
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output waitrequest, readdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  address, read, write, writedata, byteenable
    );
endinterface
`default_nettype wire

// File: rtl/lsu_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lsu_req_fifo
// Description : Request queue for the LSU; DEPTH must be a power of two >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_req_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
)(
    input  wire               clk,
    input  wire               reset,
    input  wire               push,
    input  wire  [DATA_W-1:0] din,
    input  wire               pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/mips_bus_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_lsu
// Description : Queued load/store unit from the multicycle MIPS core to an
//               Avalon-MM master; optional MIPS_BUS_LSU_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_lsu
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 0
)(
    input  wire             clk,
    input  wire             reset,
    mips_bus_lsu_if.master  lsu,
    output logic            busy
);
    localparam int PAY_W = 4 + ADDR_W + 32;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit   TO_EN = (TIMEOUT_CYC > 0);

    lsu_state_t        r_state, w_next;
    logic              w_push, w_pop, w_full, w_empty;
    logic [PAY_W-1:0]  w_fifo_din, w_fifo_dout;
    logic              w_q_write, w_q_sgn, w_q_trap;
    size_t             w_q_size;
    logic [ADDR_W-1:0] w_q_addr;
    logic [31:0]       w_q_wdata;

    logic              r_cmd_write, r_cmd_sgn, r_cmd_trap;
    size_t             r_cmd_size;
    logic [1:0]        r_cmd_off;
    logic [ADDR_W-1:0] r_address;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [TO_W-1:0]   r_wait_cnt;
    logic              r_resp_valid, r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic              w_done, w_err, w_timeout, w_strobe;

    assign w_push     = lsu.req_valid && !w_full;
    assign w_fifo_din = {lsu.req_write, norm_size(lsu.req_size), lsu.req_signed,
                         lsu.req_addr, lsu.req_wdata};

    lsu_req_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (PAY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_fifo_din),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_q_write = w_fifo_dout[PAY_W-1];
    assign w_q_size  = size_t'(w_fifo_dout[PAY_W-2 -: 2]);
    assign w_q_sgn   = w_fifo_dout[PAY_W-4];
    assign w_q_addr  = w_fifo_dout[32 +: ADDR_W];
    assign w_q_wdata = w_fifo_dout[31:0];

`ifdef MIPS_BUS_LSU_MISALIGN_TRAP_EN
    assign w_q_trap = is_misaligned(w_q_size, w_q_addr[1:0]);
`else
    assign w_q_trap = 1'b0;
`endif

    assign w_timeout = TO_EN && (r_wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = BUS;
                end
            end
            BUS: begin
                if (r_cmd_trap) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                    w_next = IDLE;
                end else if (!lsu.waitrequest) begin
                    w_done = r_cmd_write;
                    w_next = r_cmd_write ? IDLE : RDATA;
                end else if (w_timeout) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                    w_next = IDLE;
                end
            end
            RDATA:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_write  <= 1'b0;
            r_cmd_sgn    <= 1'b0;
            r_cmd_trap   <= 1'b0;
            r_cmd_size   <= SZ_BYTE;
            r_cmd_off    <= 2'b00;
            r_address    <= '0;
            r_be         <= 4'b0000;
            r_wdata      <= '0;
            r_wait_cnt   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_done || (r_state == RDATA);
            r_resp_err   <= w_err;
            r_resp_rdata <= (r_state == RDATA)
                          ? lane_extract(r_cmd_size, r_cmd_sgn, r_cmd_off, lsu.readdata)
                          : 32'h0;
            if (w_pop) begin
                r_cmd_write <= w_q_write;
                r_cmd_sgn   <= w_q_sgn;
                r_cmd_trap  <= w_q_trap;
                r_cmd_size  <= w_q_size;
                r_cmd_off   <= w_q_addr[1:0];
                r_address   <= {w_q_addr[ADDR_W-1:2], 2'b00};
                r_be        <= lane_be(w_q_size, w_q_addr[1:0]);
                r_wdata     <= lane_wdata(w_q_size, w_q_wdata);
            end
            if (w_strobe && lsu.waitrequest) r_wait_cnt <= r_wait_cnt + TO_W'(1);
            else                             r_wait_cnt <= '0;
        end
    end

    assign w_strobe       = (r_state == BUS) && !r_cmd_trap;
    assign lsu.read       = w_strobe && !r_cmd_write;
    assign lsu.write      = w_strobe && r_cmd_write;
    assign lsu.address    = r_address;
    assign lsu.byteenable = r_be;
    assign lsu.writedata  = r_wdata;
    assign lsu.req_ready  = !w_full;
    assign lsu.resp_valid = r_resp_valid;
    assign lsu.resp_err   = r_resp_err;
    assign lsu.resp_rdata = r_resp_rdata;
    assign busy           = (r_state != IDLE) || !w_empty;
endmodule
`default_nettype wire

// File: tb/tb_mips_bus_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_lsu
// Description : Scoreboard bench for mips_bus_lsu with an Avalon slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_lsu;
    logic clk;
    logic reset;
    logic busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_bus_lsu_if #(.ADDR_W(32)) bus_if();

    mips_bus_lsu #(
        .ADDR_W      (32),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .lsu   (bus_if),
        .busy  (busy)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdval;
    } bus_exp_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc_cyc;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    bus_exp_t  slv_e;
    resp_exp_t mon_r;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stall_len = 0;
    int strobe_run = 0;
    int last_run = 0;
    int total_strobes = 0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_next = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference lane model, built byte by byte.
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) begin
            if (sz == 2'd0)      be[i] = (i == int'(a[1:0]));
            else if (sz == 2'd1) be[i] = ((i / 2) == int'(a[1]));
            else                 be[i] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            if (sz == 2'd0)      w[8*i +: 8] = d[7:0];
            else if (sz == 2'd1) w[8*i +: 8] = (i % 2 == 1) ? d[15:8] : d[7:0];
            else                 w[8*i +: 8] = d[8*i +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        if (sz == 2'd0) begin
            b = rd[8*int'(a[1:0]) +: 8];
            return (sgn && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
        end else if (sz == 2'd1) begin
            h = rd[16*int'(a[1]) +: 16];
            return (sgn && h[15]) ? {16'hFFFF, h} : {16'h0, h};
        end
        return rd;
    endfunction

    function automatic logic m_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef MIPS_BUS_LSU_MISALIGN_TRAP_EN
        return ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'b00));
`else
        return 1'b0 & sz[0] & a[0];
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Avalon slave: stalls the first stall_len cycles of every strobe run.
    always @(negedge clk) begin
        bus_if.readdata = rd_pend ? rd_next : 32'h5A5A_5A5A;
        rd_pend = 1'b0;
        if (bus_if.read || bus_if.write) begin
            total_strobes++;
            strobe_run++;
            if (strobe_run <= stall_len) begin
                bus_if.waitrequest = 1'b1;
            end else begin
                bus_if.waitrequest = 1'b0;
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    slv_e = bus_q.pop_front();
                    check("bus_dir",  {31'd0, bus_if.write}, {31'd0, slv_e.write});
                    check("bus_addr", bus_if.address, slv_e.addr);
                    check("bus_be",   {28'd0, bus_if.byteenable}, {28'd0, slv_e.be});
                    if (slv_e.write) check("bus_wdata", bus_if.writedata, slv_e.wdata);
                    else begin
                        rd_pend = 1'b1;
                        rd_next = slv_e.rdval;
                    end
                end
            end
        end else begin
            bus_if.waitrequest = 1'b0;
            if (strobe_run > 0) last_run = strobe_run;
            strobe_run = 0;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && bus_if.resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_r = resp_q.pop_front();
                check("resp_err",   {31'd0, bus_if.resp_err}, {31'd0, mon_r.err});
                check("resp_rdata", bus_if.resp_rdata, mon_r.rdata);
                if (mon_r.lat > 0) check("resp_latency", cyc - mon_r.acc_cyc, mon_r.lat);
            end
        end
    end

    // kind: 0 normal, 1 expect timeout, 2 aborted by reset (no response)
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdval, input int lat, input int kind);
        int g;
        logic trap;
        bus_exp_t  be_e;
        resp_exp_t re_e;
        bus_if.req_valid  = 1'b1;
        bus_if.req_write  = wr;
        bus_if.req_size   = sz;
        bus_if.req_signed = sgn;
        bus_if.req_addr   = a;
        bus_if.req_wdata  = wd;
        g = 0;
        while (!bus_if.req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!bus_if.req_ready) begin
            check("req_ready_wait", 32'd0, 32'd1);
            bus_if.req_valid = 1'b0;
            return;
        end
        trap = m_trap(sz, a);
        if (kind == 0 && !trap) begin
            be_e.write = wr;
            be_e.addr  = {a[31:2], 2'b00};
            be_e.be    = m_be(sz, a);
            be_e.wdata = m_wdata(sz, wd);
            be_e.rdval = rdval;
            bus_q.push_back(be_e);
        end
        if (kind != 2) begin
            re_e.err     = (kind == 1) || trap;
            re_e.rdata   = (kind == 0 && !trap && !wr) ? m_rdata(sz, sgn, a, rdval) : 32'h0;
            re_e.lat     = lat;
            re_e.acc_cyc = cyc + 1;
            resp_q.push_back(re_e);
        end
        @(negedge clk);
        bus_if.req_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((resp_q.size() != 0 || busy) && g < 400) begin
            @(negedge clk);
            g++;
        end
        check("drain_done", {31'd0, (resp_q.size() == 0) && !busy}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int g;
        int t0;
        reset = 1'b0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_write  = 1'b0;
        bus_if.req_size   = 2'd0;
        bus_if.req_signed = 1'b0;
        bus_if.req_addr   = 32'h0;
        bus_if.req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  {31'd0, bus_if.req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        check("rst_resp_err",   {31'd0, bus_if.resp_err},   32'd0);
        check("rst_resp_rdata", bus_if.resp_rdata,          32'd0);
        check("rst_read",       {31'd0, bus_if.read},       32'd0);
        check("rst_write",      {31'd0, bus_if.write},      32'd0);
        check("rst_address",    bus_if.address,             32'd0);
        check("rst_be",         {28'd0, bus_if.byteenable}, 32'd0);
        check("rst_wdata",      bus_if.writedata,           32'd0);
        check("rst_busy",       {31'd0, busy},              32'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF, 3, 0); drain();
        issue(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FFFFFF, 3, 0); drain();
        issue(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FFFFFF, 3, 0); drain();
        issue(1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 32'h80011234, 3, 0);
        issue(1'b0, 2'd1, 1'b0, 32'h1000, 32'h0, 32'h8001F234, 0, 0); drain();
        issue(1'b1, 2'd0, 1'b0, 32'h3001, 32'h000000A5, 32'h0, 2, 0); drain();
        issue(1'b1, 2'd2, 1'b0, 32'h3000, 32'hCAFEF00D, 32'h0, 2, 0); drain();

        stall_len = 5;
        issue(1'b1, 2'd1, 1'b0, 32'h2002, 32'h00001234, 32'h0, 0, 0); drain();
        check("sh_strobe_cycles", last_run, 32'd6);

        for (int i = 0; i < 5; i++)
            issue(1'b0, 2'd2, 1'b0, 32'h5000 + 32'(4*i), 32'h0, 32'h11110000 + 32'(i), 0, 0);
        check("fifo_full_ready", {31'd0, bus_if.req_ready}, 32'd0);
        drain();

        stall_len = 1000;
        issue(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 9, 1); drain();
        check("timeout_strobe_cycles", last_run, 32'd8);
        stall_len = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h4004, 32'h0, 32'h0BADCAFE, 3, 0); drain();

        t0 = total_strobes;
`ifdef MIPS_BUS_LSU_MISALIGN_TRAP_EN
        issue(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 32'h76543210, 2, 0); drain();
        check("misalign_strobes", total_strobes - t0, 32'd0);
`else
        issue(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 32'h76543210, 3, 0); drain();
        check("misalign_strobes", total_strobes - t0, 32'd1);
`endif

        stall_len = 1000;
        issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0, 32'h0, 0, 2);
        g = 0;
        while (!bus_if.read && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("abort_read_seen", {31'd0, bus_if.read}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_read",  {31'd0, bus_if.read},      32'd0);
        check("abort_busy",  {31'd0, busy},             32'd0);
        check("abort_ready", {31'd0, bus_if.req_ready}, 32'd1);
        stall_len = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        issue(1'b0, 2'd1, 1'b1, 32'h7002, 32'h0, 32'hC3A5_0000, 3, 0); drain();

        check("bus_q_empty", bus_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
